switch_sync_debounce: RTL and testbench

- Input conditioning stage that sits directly upstream of the team's x/y/z combinational logic blocks.
- Takes three raw, asynchronous, bouncy switch inputs and passes each through a 2-flop synchronizer and a per-bit debounce counter.
- Drives clean, registered x, y, z levels plus a one-cycle change strobe, so the downstream f1/f2 logic only ever sees stable inputs.

---
 rtl/switch_sync_debounce.sv | 73 +++++++
 tb/tb_switch_sync_debounce.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/switch_sync_debounce.sv
// Purpose: conditions three raw bouncy switches into stable x/y/z levels plus a change strobe.
// Latency: a stable raw change reaches the outputs DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Backpressure: none; free-running input stage, every output comes straight from a flop.
module switch_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sw_raw,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] sync_s1;
    logic [2:0] sync_s2;
    logic [2:0] deb_q;
    logic [2:0] upd;

    // Plain two-flop synchronizer; s1 must feed only s2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1 <= 3'b000;
            sync_s2 <= 3'b000;
        end else begin
            sync_s1 <= sw_raw;
            sync_s2 <= sync_s1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_bit
        logic [CNT_W-1:0] cnt;
        logic             q;
        logic             differs;

        assign differs  = (sync_s2[i] != q);
        assign upd[i]   = differs && (cnt == CNT_MAX);
        assign deb_q[i] = q;

        // Any cycle where the input agrees with the output restarts the full count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (!differs) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                q   <= sync_s2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered alongside the output update so it is high for the cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |upd;
        end
    end

    assign x = deb_q[2];
    assign y = deb_q[1];
    assign z = deb_q[0];

endmodule

// File: tb/tb_switch_sync_debounce.sv
// Directed bench for switch_sync_debounce at DEBOUNCE_CYCLES=4; inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_switch_sync_debounce;

    logic       clk;
    logic       rst_n;
    logic [2:0] sw_raw;
    logic       x;
    logic       y;
    logic       z;
    logic       changed;

    int n_tests;
    int n_fail;

    switch_sync_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .x       (x),
        .y       (y),
        .z       (z),
        .changed (changed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] exp_xyz, input logic exp_chg);
        check({tag, " xyz"}, {1'b0, x, y, z}, {1'b0, exp_xyz});
        check({tag, " changed"}, {3'b000, changed}, {3'b000, exp_chg});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sw_raw must already hold its new value before edge 1; expects update at edge 6.
    task automatic expect_update(input string tag, input logic [2:0] before_xyz,
                                 input logic [2:0] after_xyz);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6)
                check_out($sformatf("%s e%0d", tag, k), before_xyz, 1'b0);
            else if (k == 6)
                check_out($sformatf("%s e%0d", tag, k), after_xyz, 1'b1);
            else
                check_out($sformatf("%s e%0d", tag, k), after_xyz, 1'b0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        sw_raw  = 3'b000;

        // Reset and quiet run
        #2 rst_n = 1'b0;
        #1 check_out("reset", 3'b000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_out($sformatf("idle c%0d", k), 3'b000, 1'b0);
        end

        // x rises at edge 6, not 5
        sw_raw = 3'b100;
        expect_update("x_rise", 3'b000, 3'b100);

        // Asynchronous reset in mid-cycle clears outputs without a clock edge
        #3 rst_n = 1'b0;
        #1 check_out("async_rst", 3'b000, 1'b0);
        sw_raw = 3'b000;
        #2 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_out($sformatf("post_rst c%0d", k), 3'b000, 1'b0);
        end

        // Bounce on x_raw: 2-cycle high pulses never reach x
        for (int p = 0; p < 2; p++) begin
            sw_raw = 3'b100;
            for (int k = 0; k < 2; k++) begin
                tick();
                check_out($sformatf("bounce p%0d h%0d", p, k), 3'b000, 1'b0);
            end
            sw_raw = 3'b000;
            for (int k = 0; k < 2; k++) begin
                tick();
                check_out($sformatf("bounce p%0d l%0d", p, k), 3'b000, 1'b0);
            end
        end
        sw_raw = 3'b100;
        expect_update("bounce_final", 3'b000, 3'b100);

        // Return x to 0
        sw_raw = 3'b000;
        expect_update("x_fall", 3'b100, 3'b000);

        // Simultaneous y/z rise gives one pulse, then y falls alone
        sw_raw = 3'b011;
        expect_update("yz_rise", 3'b000, 3'b011);
        sw_raw = 3'b001;
        expect_update("y_fall", 3'b011, 3'b001);

        // Reset mid-count on y drops progress; both y and z recover after release
        sw_raw = 3'b011;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_out($sformatf("mid_cnt e%0d", k), 3'b001, 1'b0);
        end
        #3 rst_n = 1'b0;
        #1 check_out("mid_cnt rst", 3'b000, 1'b0);
        #2 rst_n = 1'b1;
        expect_update("after_rel", 3'b000, 3'b011);

        // Settle to zero, then a 3-cycle z glitch must be rejected
        sw_raw = 3'b000;
        expect_update("settle", 3'b011, 3'b000);
        sw_raw = 3'b001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("glitch h%0d", k), 3'b000, 1'b0);
        end
        sw_raw = 3'b000;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_out($sformatf("glitch l%0d", k), 3'b000, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
